// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the sargantana instruction-cache refill path.
package sargantana_icache_pkg;

    // Default geometry of the icache line-fill path.
    localparam int ICACHE_PADDR_WIDTH = 40;
    localparam int ICACHE_LINE_WIDTH  = 256;
    localparam int ICACHE_BEAT_WIDTH  = 64;
    localparam int ICACHE_N_WAY       = 4;

    localparam int N_BEATS         = ICACHE_LINE_WIDTH / ICACHE_BEAT_WIDTH;
    localparam int BEAT_IDX_WIDTH  = $clog2(N_BEATS);
    localparam int WAY_IDX_WIDTH   = $clog2(ICACHE_N_WAY);

    // Refill engine states.
    typedef enum logic [1:0] {
        REFILL_IDLE  = 2'd0,
        REFILL_REQ   = 2'd1,
        REFILL_BEATS = 2'd2,
        REFILL_DONE  = 2'd3
    } refill_state_t;

    // Line-fill request coming from the icache.
    typedef struct packed {
        logic [ICACHE_PADDR_WIDTH-1:0] paddr;
        logic [WAY_IDX_WIDTH-1:0]      way;
    } refill_req_t;

    // Line-aligned read request towards L2.
    typedef struct packed {
        logic                          valid;
        logic [ICACHE_PADDR_WIDTH-1:0] paddr;
    } l2_req_t;

    // One L2 response beat.
    typedef struct packed {
        logic                         valid;
        logic [ICACHE_BEAT_WIDTH-1:0] data;
        logic                         last;
    } l2_resp_t;

    // Assembled line handed back to the icache.
    typedef struct packed {
        logic                          valid;
        logic [ICACHE_LINE_WIDTH-1:0]  data;
        logic [ICACHE_PADDR_WIDTH-1:0] paddr;
        logic [WAY_IDX_WIDTH-1:0]      way;
    } ifill_resp_t;

endpackage

// File: rtl/sargantana_icache_line_assembler.sv
// Beat counter plus line register: collects L2 beats into one cache line.
module sargantana_icache_line_assembler
    import sargantana_icache_pkg::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int NB         = LINE_WIDTH / BEAT_WIDTH,
    parameter int IDX_W      = $clog2(NB)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  we_i,
    input  logic [BEAT_WIDTH-1:0] data_i,
    output logic                  last_o,
    output logic [LINE_WIDTH-1:0] line_o
);

    logic [IDX_W-1:0] cnt_q;

    // Beat index: cleared at the start of a fill, advances (and wraps) per beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (we_i) begin
            cnt_q <= cnt_q + IDX_W'(1);
        end
    end

    assign last_o = (cnt_q == IDX_W'(NB - 1));

    // One register per beat slot so each slice has a single driver.
    for (genvar gi = 0; gi < NB; gi++) begin : g_beat
        logic [BEAT_WIDTH-1:0] beat_q;

        // Capture the incoming beat into the slot selected by the counter.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                beat_q <= '0;
            end else if (we_i && (cnt_q == IDX_W'(gi))) begin
                beat_q <= data_i;
            end
        end

        assign line_o[gi*BEAT_WIDTH +: BEAT_WIDTH] = beat_q;
    end

endmodule

// File: rtl/sargantana_icache_refill_unit.sv
// Icache miss-refill engine: one L2 line read per request, beat assembly,
// one-cycle fill response, and invalidation forwarding with priority over fills.
module sargantana_icache_refill_unit
    import sargantana_icache_pkg::*;
#(
    parameter int PADDR_WIDTH = 40,
    parameter int LINE_WIDTH  = 256,
    parameter int BEAT_WIDTH  = 64,
    parameter int N_WAY       = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    input  logic [PADDR_WIDTH-1:0]   req_paddr_i,
    input  logic [$clog2(N_WAY)-1:0] req_way_i,
    input  logic                     req_kill_i,
    output logic                     busy_o,
    output logic                     l2_req_valid_o,
    input  logic                     l2_req_ready_i,
    output logic [PADDR_WIDTH-1:0]   l2_req_paddr_o,
    input  logic                     l2_resp_valid_i,
    input  logic [BEAT_WIDTH-1:0]    l2_resp_data_i,
    input  logic                     l2_resp_last_i,
    input  logic                     l2_inv_valid_i,
    input  logic [PADDR_WIDTH-1:0]   l2_inv_paddr_i,
    output logic                     fill_valid_o,
    output logic [LINE_WIDTH-1:0]    fill_data_o,
    output logic [PADDR_WIDTH-1:0]   fill_paddr_o,
    output logic [$clog2(N_WAY)-1:0] fill_way_o,
    output logic                     inv_valid_o,
    output logic [PADDR_WIDTH-1:0]   inv_paddr_o,
    output logic                     protocol_err_o
);

    localparam int WAY_W = $clog2(N_WAY);
    localparam int OFF   = $clog2(LINE_WIDTH / 8);
    localparam logic [PADDR_WIDTH-1:0] OFF_MASK = {{(PADDR_WIDTH-OFF){1'b0}}, {OFF{1'b1}}};

    refill_state_t          state_q, state_d;
    logic                   killed_q, killed_d;
    logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [WAY_W-1:0]       way_q, way_d;
    logic                   err_q, err_d;
    logic                   inv_valid_q;
    logic [PADDR_WIDTH-1:0] inv_paddr_q;
    logic                   asm_clear, asm_we, asm_last;
    logic                   inv_hit;

    sargantana_icache_line_assembler #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_assembler (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (asm_clear),
        .we_i    (asm_we),
        .data_i  (l2_resp_data_i),
        .last_o  (asm_last),
        .line_o  (fill_data_o)
    );

    // State, request latch, error pulse and the one-cycle invalidation pipe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= REFILL_IDLE;
            killed_q    <= 1'b0;
            paddr_q     <= '0;
            way_q       <= '0;
            err_q       <= 1'b0;
            inv_valid_q <= 1'b0;
            inv_paddr_q <= '0;
        end else begin
            state_q     <= state_d;
            killed_q    <= killed_d;
            paddr_q     <= paddr_d;
            way_q       <= way_d;
            err_q       <= err_d;
            inv_valid_q <= l2_inv_valid_i;
            inv_paddr_q <= l2_inv_paddr_i;
        end
    end

    // Next-state logic; killed fills still drain every beat so L2 stays in sync.
    always_comb begin
        state_d   = state_q;
        killed_d  = killed_q;
        paddr_d   = paddr_q;
        way_d     = way_q;
        err_d     = 1'b0;
        asm_clear = 1'b0;
        asm_we    = 1'b0;
        inv_hit   = l2_inv_valid_i &&
                    (l2_inv_paddr_i[PADDR_WIDTH-1:OFF] == paddr_q[PADDR_WIDTH-1:OFF]);
        case (state_q)
            REFILL_IDLE: begin
                err_d = l2_resp_valid_i;
                if (req_valid_i && !req_kill_i) begin
                    paddr_d   = req_paddr_i & ~OFF_MASK;
                    way_d     = req_way_i;
                    killed_d  = 1'b0;
                    asm_clear = 1'b1;
                    state_d   = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                err_d = l2_resp_valid_i;
                if (req_kill_i || inv_hit) killed_d = 1'b1;
                if (l2_req_ready_i) state_d = REFILL_BEATS;
            end
            REFILL_BEATS: begin
                if (req_kill_i || inv_hit) killed_d = 1'b1;
                if (l2_resp_valid_i) begin
                    asm_we = 1'b1;
                    err_d  = (l2_resp_last_i != asm_last);
                    // The counter, not the last flag, decides completion.
                    if (asm_last) state_d = killed_d ? REFILL_IDLE : REFILL_DONE;
                end
            end
            REFILL_DONE: begin
                err_d = l2_resp_valid_i;
                if (req_kill_i) begin
                    killed_d = 1'b1;
                    state_d  = REFILL_IDLE;
                end else if (!inv_valid_q) begin
                    state_d = REFILL_IDLE;
                end
            end
            default: state_d = REFILL_IDLE;
        endcase
    end

    assign busy_o         = (state_q != REFILL_IDLE);
    assign l2_req_valid_o = (state_q == REFILL_REQ);
    assign l2_req_paddr_o = paddr_q;
    // A forwarded invalidation owns the tag-write port, so the fill waits.
    assign fill_valid_o   = (state_q == REFILL_DONE) && !inv_valid_q && !req_kill_i && !killed_q;
    assign fill_paddr_o   = paddr_q;
    assign fill_way_o     = way_q;
    assign inv_valid_o    = inv_valid_q;
    assign inv_paddr_o    = inv_paddr_q;
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_sargantana_icache_refill_unit.sv
// Directed testbench for the icache refill unit.
module tb_sargantana_icache_refill_unit;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic [39:0]  req_paddr_i;
    logic [1:0]   req_way_i;
    logic         req_kill_i;
    logic         busy_o;
    logic         l2_req_valid_o;
    logic         l2_req_ready_i;
    logic [39:0]  l2_req_paddr_o;
    logic         l2_resp_valid_i;
    logic [63:0]  l2_resp_data_i;
    logic         l2_resp_last_i;
    logic         l2_inv_valid_i;
    logic [39:0]  l2_inv_paddr_i;
    logic         fill_valid_o;
    logic [255:0] fill_data_o;
    logic [39:0]  fill_paddr_o;
    logic [1:0]   fill_way_o;
    logic         inv_valid_o;
    logic [39:0]  inv_paddr_o;
    logic         protocol_err_o;

    int total = 0;
    int bad   = 0;
    int fill_seen = 0;
    int err_seen  = 0;

    sargantana_icache_refill_unit dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_paddr_i     (req_paddr_i),
        .req_way_i       (req_way_i),
        .req_kill_i      (req_kill_i),
        .busy_o          (busy_o),
        .l2_req_valid_o  (l2_req_valid_o),
        .l2_req_ready_i  (l2_req_ready_i),
        .l2_req_paddr_o  (l2_req_paddr_o),
        .l2_resp_valid_i (l2_resp_valid_i),
        .l2_resp_data_i  (l2_resp_data_i),
        .l2_resp_last_i  (l2_resp_last_i),
        .l2_inv_valid_i  (l2_inv_valid_i),
        .l2_inv_paddr_i  (l2_inv_paddr_i),
        .fill_valid_o    (fill_valid_o),
        .fill_data_o     (fill_data_o),
        .fill_paddr_o    (fill_paddr_o),
        .fill_way_o      (fill_way_o),
        .inv_valid_o     (inv_valid_o),
        .inv_paddr_o     (inv_paddr_o),
        .protocol_err_o  (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Count fill and error pulses away from the active edge.
    always @(negedge clk_i) begin
        if (!rst_i && fill_valid_o) fill_seen <= fill_seen + 1;
        if (!rst_i && protocol_err_o) err_seen <= err_seen + 1;
    end

    // A new request must only be offered while the unit is idle.
    always @(negedge clk_i) begin
        if (!rst_i) assert (!(req_valid_i && busy_o)) else $error("req_valid_i asserted while busy_o");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_req(input logic [39:0] addr, input logic [1:0] way);
        req_valid_i = 1'b1;
        req_paddr_i = addr;
        req_way_i   = way;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic handshake;
        l2_req_ready_i = 1'b1;
        tick();
        l2_req_ready_i = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] data, input logic last);
        l2_resp_valid_i = 1'b1;
        l2_resp_data_i  = data;
        l2_resp_last_i  = last;
        tick();
        l2_resp_valid_i = 1'b0;
        l2_resp_last_i  = 1'b0;
    endtask

    // Complete fill with immediate ready and back-to-back beats.
    task automatic run_plain_fill(input logic [39:0] addr, input logic [1:0] way,
                                  input logic [39:0] exp_addr, input logic [31:0] seed);
        logic [255:0] exp_line;
        logic [63:0]  b;
        int f0;
        f0 = fill_seen;
        send_req(addr, way);
        total++; if (l2_req_paddr_o !== exp_addr) begin bad++; $display("FAIL plain_l2_paddr got=%h exp=%h", l2_req_paddr_o, exp_addr); end
        handshake();
        for (int i = 0; i < 4; i++) begin
            b = {32'hA5A50000 + 32'(i), seed};
            exp_line[i*64 +: 64] = b;
            send_beat(b, i == 3);
        end
        total++; if (fill_valid_o !== 1'b1) begin bad++; $display("FAIL plain_fill_valid got=%b exp=1", fill_valid_o); end
        total++; if (fill_data_o !== exp_line) begin bad++; $display("FAIL plain_fill_data got=%h exp=%h", fill_data_o, exp_line); end
        total++; if (fill_paddr_o !== exp_addr) begin bad++; $display("FAIL plain_fill_paddr got=%h exp=%h", fill_paddr_o, exp_addr); end
        total++; if (fill_way_o !== way) begin bad++; $display("FAIL plain_fill_way got=%0d exp=%0d", fill_way_o, way); end
        tick();
        total++; if (busy_o !== 1'b0 || fill_valid_o !== 1'b0) begin bad++; $display("FAIL plain_end busy=%b fill=%b exp=0,0", busy_o, fill_valid_o); end
        total++; if (fill_seen - f0 !== 1) begin bad++; $display("FAIL plain_fill_count got=%0d exp=1", fill_seen - f0); end
        $display("fill addr=%h way=%0d seed=%h", exp_addr, way, seed);
    endtask

    task automatic test_reset;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (l2_req_valid_o !== 1'b0) begin bad++; $display("FAIL reset_l2_req got=%b exp=0", l2_req_valid_o); end
        total++; if (fill_valid_o !== 1'b0) begin bad++; $display("FAIL reset_fill got=%b exp=0", fill_valid_o); end
        total++; if (inv_valid_o !== 1'b0 || protocol_err_o !== 1'b0) begin bad++; $display("FAIL reset_inv_err inv=%b err=%b exp=0,0", inv_valid_o, protocol_err_o); end
        total++; if (fill_data_o !== 256'd0 || l2_req_paddr_o !== 40'd0 || inv_paddr_o !== 40'd0) begin bad++; $display("FAIL reset_data data=%h paddr=%h inv=%h exp=0", fill_data_o, l2_req_paddr_o, inv_paddr_o); end
        $display("reset checked");
    endtask

    task automatic test_basic;
        logic [255:0] exp_line;
        int f0, e0;
        exp_line = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        f0 = fill_seen; e0 = err_seen;
        send_req(40'h80001234, 2'd2);
        total++; if (l2_req_valid_o !== 1'b1) begin bad++; $display("FAIL basic_req_valid got=%b exp=1", l2_req_valid_o); end
        total++; if (l2_req_paddr_o !== 40'h80001220) begin bad++; $display("FAIL basic_req_paddr got=%h exp=80001220", l2_req_paddr_o); end
        handshake();
        total++; if (l2_req_valid_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL basic_beats_entry req=%b busy=%b exp=0,1", l2_req_valid_o, busy_o); end
        for (int i = 0; i < 4; i++) begin
            total++; if (fill_valid_o !== 1'b0) begin bad++; $display("FAIL basic_early_fill beat=%0d got=%b exp=0", i, fill_valid_o); end
            send_beat(exp_line[i*64 +: 64], i == 3);
        end
        total++; if (fill_valid_o !== 1'b1) begin bad++; $display("FAIL basic_fill_t6 got=%b exp=1", fill_valid_o); end
        total++; if (fill_data_o !== exp_line) begin bad++; $display("FAIL basic_fill_data got=%h exp=%h", fill_data_o, exp_line); end
        total++; if (fill_way_o !== 2'd2 || fill_paddr_o !== 40'h80001220) begin bad++; $display("FAIL basic_fill_meta way=%0d paddr=%h exp=2,80001220", fill_way_o, fill_paddr_o); end
        tick();
        total++; if (fill_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL basic_end fill=%b busy=%b exp=0,0", fill_valid_o, busy_o); end
        total++; if (fill_seen - f0 !== 1 || err_seen - e0 !== 0) begin bad++; $display("FAIL basic_counts fills=%0d errs=%0d exp=1,0", fill_seen - f0, err_seen - e0); end
        $display("basic fill done");
    endtask

    task automatic test_backpressure;
        logic [255:0] exp_line;
        int f0, e0;
        exp_line = {64'hD0D0D0D0D0D0D0D3, 64'hC0C0C0C0C0C0C0C2, 64'hB0B0B0B0B0B0B0B1, 64'hA0A0A0A0A0A0A0A0};
        f0 = fill_seen; e0 = err_seen;
        send_req(40'h00001FFFDF, 2'd1);
        for (int i = 0; i < 3; i++) begin
            total++; if (l2_req_valid_o !== 1'b1 || l2_req_paddr_o !== 40'h00001FFFC0) begin bad++; $display("FAIL bp_req_hold cyc=%0d valid=%b paddr=%h exp=1,1fffc0", i, l2_req_valid_o, l2_req_paddr_o); end
            tick();
        end
        handshake();
        for (int i = 0; i < 4; i++) begin
            send_beat(exp_line[i*64 +: 64], i == 3);
            if (i < 3) begin
                total++; if (fill_valid_o !== 1'b0) begin bad++; $display("FAIL bp_early_fill beat=%0d got=%b exp=0", i, fill_valid_o); end
                tick();
                tick();
            end
        end
        total++; if (fill_valid_o !== 1'b1 || fill_data_o !== exp_line) begin bad++; $display("FAIL bp_fill valid=%b data=%h exp=1,%h", fill_valid_o, fill_data_o, exp_line); end
        tick();
        total++; if (fill_seen - f0 !== 1 || err_seen - e0 !== 0) begin bad++; $display("FAIL bp_counts fills=%0d errs=%0d exp=1,0", fill_seen - f0, err_seen - e0); end
        $display("backpressure fill done");
    endtask

    task automatic test_kill;
        int f0;
        f0 = fill_seen;
        send_req(40'h40000040, 2'd3);
        handshake();
        send_beat(64'h0101010101010101, 1'b0);
        req_kill_i = 1'b1;
        tick();
        req_kill_i = 1'b0;
        send_beat(64'h0202020202020202, 1'b0);
        send_beat(64'h0303030303030303, 1'b0);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL kill_still_busy got=%b exp=1", busy_o); end
        send_beat(64'h0404040404040404, 1'b1);
        total++; if (busy_o !== 1'b0 || fill_valid_o !== 1'b0) begin bad++; $display("FAIL kill_end busy=%b fill=%b exp=0,0", busy_o, fill_valid_o); end
        tick();
        total++; if (fill_seen - f0 !== 0) begin bad++; $display("FAIL kill_no_fill got=%0d exp=0", fill_seen - f0); end
        $display("killed fill drained");
    endtask

    task automatic test_inv_collision;
        int f0;
        f0 = fill_seen;
        send_req(40'h80002000, 2'd0);
        handshake();
        send_beat(64'h5555555555555555, 1'b0);
        l2_inv_valid_i = 1'b1;
        l2_inv_paddr_i = 40'h80002010;
        tick();
        l2_inv_valid_i = 1'b0;
        total++; if (inv_valid_o !== 1'b1 || inv_paddr_o !== 40'h80002010) begin bad++; $display("FAIL inv_fwd valid=%b paddr=%h exp=1,80002010", inv_valid_o, inv_paddr_o); end
        tick();
        total++; if (inv_valid_o !== 1'b0) begin bad++; $display("FAIL inv_one_cycle got=%b exp=0", inv_valid_o); end
        for (int i = 1; i < 4; i++) send_beat(64'h6666666666666666, i == 3);
        total++; if (fill_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL inv_dropped fill=%b busy=%b exp=0,0", fill_valid_o, busy_o); end
        tick();
        total++; if (fill_seen - f0 !== 0) begin bad++; $display("FAIL inv_no_fill got=%0d exp=0", fill_seen - f0); end
        $display("invalidation collision done");
    endtask

    task automatic test_inv_delay;
        int f0;
        f0 = fill_seen;
        send_req(40'h80003000, 2'd1);
        handshake();
        for (int i = 0; i < 3; i++) send_beat(64'h7777777777777777, 1'b0);
        l2_inv_valid_i = 1'b1;
        l2_inv_paddr_i = 40'h12345000;
        send_beat(64'h8888888888888888, 1'b1);
        l2_inv_valid_i = 1'b0;
        total++; if (fill_valid_o !== 1'b0 || busy_o !== 1'b1 || inv_valid_o !== 1'b1) begin bad++; $display("FAIL invd_held fill=%b busy=%b inv=%b exp=0,1,1", fill_valid_o, busy_o, inv_valid_o); end
        tick();
        total++; if (fill_valid_o !== 1'b1 || fill_data_o[255:192] !== 64'h8888888888888888) begin bad++; $display("FAIL invd_fill valid=%b top=%h exp=1,8888888888888888", fill_valid_o, fill_data_o[255:192]); end
        tick();
        total++; if (busy_o !== 1'b0 || fill_seen - f0 !== 1) begin bad++; $display("FAIL invd_end busy=%b fills=%0d exp=0,1", busy_o, fill_seen - f0); end
        $display("delayed fill done");
    endtask

    task automatic test_protocol;
        int f0, e0;
        f0 = fill_seen; e0 = err_seen;
        send_req(40'h80004000, 2'd2);
        handshake();
        send_beat(64'h9999999999999990, 1'b0);
        send_beat(64'h9999999999999991, 1'b1);
        total++; if (protocol_err_o !== 1'b1) begin bad++; $display("FAIL proto_early_last got=%b exp=1", protocol_err_o); end
        send_beat(64'h9999999999999992, 1'b0);
        total++; if (protocol_err_o !== 1'b0) begin bad++; $display("FAIL proto_pulse_len got=%b exp=0", protocol_err_o); end
        send_beat(64'h9999999999999993, 1'b1);
        total++; if (fill_valid_o !== 1'b1 || protocol_err_o !== 1'b0) begin bad++; $display("FAIL proto_fill fill=%b err=%b exp=1,0", fill_valid_o, protocol_err_o); end
        tick();
        send_beat(64'hDEADDEADDEADDEAD, 1'b0);
        total++; if (protocol_err_o !== 1'b1) begin bad++; $display("FAIL proto_stray got=%b exp=1", protocol_err_o); end
        tick();
        total++; if (err_seen - e0 !== 2 || fill_seen - f0 !== 1) begin bad++; $display("FAIL proto_counts errs=%0d fills=%0d exp=2,1", err_seen - e0, fill_seen - f0); end
        $display("protocol errors done");
    endtask

    task automatic test_reset_midfill;
        send_req(40'h80005000, 2'd1);
        handshake();
        send_beat(64'hAAAAAAAAAAAAAAAA, 1'b0);
        send_beat(64'hBBBBBBBBBBBBBBBB, 1'b0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total++; if (busy_o !== 1'b0 || l2_req_valid_o !== 1'b0 || fill_valid_o !== 1'b0 || inv_valid_o !== 1'b0 || protocol_err_o !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl busy=%b req=%b fill=%b inv=%b err=%b exp=0", busy_o, l2_req_valid_o, fill_valid_o, inv_valid_o, protocol_err_o); end
        total++; if (fill_data_o !== 256'd0 || fill_paddr_o !== 40'd0 || fill_way_o !== 2'd0) begin bad++; $display("FAIL rstmid_data data=%h paddr=%h way=%0d exp=0", fill_data_o, fill_paddr_o, fill_way_o); end
        send_beat(64'hCCCCCCCCCCCCCCCC, 1'b0);
        total++; if (protocol_err_o !== 1'b1) begin bad++; $display("FAIL rstmid_stray1 got=%b exp=1", protocol_err_o); end
        send_beat(64'hDDDDDDDDDDDDDDDD, 1'b1);
        total++; if (protocol_err_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_stray2 err=%b busy=%b exp=1,0", protocol_err_o, busy_o); end
        tick();
        run_plain_fill(40'h9000007F, 2'd3, 40'h90000060, 32'h0000BEEF);
        $display("reset mid-fill done");
    endtask

    task automatic test_back_to_back;
        run_plain_fill(40'h0000000001, 2'd0, 40'h0000000000, 32'h11112222);
        run_plain_fill(40'hFFFFFFFFFF, 2'd3, 40'hFFFFFFFFE0, 32'h33334444);
        $display("back-to-back fills done");
    endtask

    initial begin
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_paddr_i = '0; req_way_i = '0; req_kill_i = 1'b0;
        l2_req_ready_i = 1'b0; l2_resp_valid_i = 1'b0; l2_resp_data_i = '0; l2_resp_last_i = 1'b0;
        l2_inv_valid_i = 1'b0; l2_inv_paddr_i = '0;
        tick();
        tick();
        test_reset();
        rst_i = 1'b0;
        tick();
        test_basic();
        test_backpressure();
        test_kill();
        test_inv_collision();
        test_inv_delay();
        test_protocol();
        test_reset_midfill();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_refill_unit.md
# sargantana_icache_refill_unit

Miss-refill engine directly downstream of the instruction cache's ifill request port. It accepts one line-fill request (physical line address plus victim way) and issues a single line-aligned read to L2. It collects the returned beats into a full cache line and hands the line back to the icache as a one-cycle fill response. It also forwards L2 invalidations to the icache and arbitrates them against fills.

## Interface
Parameters:
- PADDR_WIDTH, 40: physical address width.
- LINE_WIDTH, 256: cache-line width in bits (32-byte line).
- BEAT_WIDTH, 64: L2 response beat width; N_BEATS = LINE_WIDTH/BEAT_WIDTH (4), a power of two.
- N_WAY, 4: icache associativity.

Ports (name, direction, width, meaning):
- clk_i, in, 1: sole clock.
- rst_i, in, 1: reset, synchronous, active-high.
- req_valid_i, in, 1: fill request from the icache.
- req_paddr_i, in, PADDR_WIDTH: miss address; the low 5 bits are ignored.
- req_way_i, in, log2(N_WAY): victim way.
- req_kill_i, in, 1: abort the current fill.
- busy_o, out, 1: the FSM is not in IDLE.
- l2_req_valid_o, out, 1: read request to L2.
- l2_req_ready_i, in, 1: L2 accepts the request.
- l2_req_paddr_o, out, PADDR_WIDTH: line-aligned address.
- l2_resp_valid_i, in, 1: a data beat is present.
- l2_resp_data_i, in, BEAT_WIDTH: beat data.
- l2_resp_last_i, in, 1: final beat.
- l2_inv_valid_i, in, 1: invalidation request from L2.
- l2_inv_paddr_i, in, PADDR_WIDTH: address to invalidate.
- fill_valid_o, out, 1: an assembled line is ready.
- fill_data_o, out, LINE_WIDTH: the assembled line.
- fill_paddr_o, out, PADDR_WIDTH: the line's address.
- fill_way_o, out, log2(N_WAY): the victim way.
- inv_valid_o, out, 1: invalidation forwarded to the icache.
- inv_paddr_o, out, PADDR_WIDTH: the forwarded invalidation address.
- protocol_err_o, out, 1: one-cycle pulse on an L2 protocol violation.

## Operation
- States: IDLE, REQ, BEATS, DONE.
- **IDLE**
  - When req_valid_i & ~req_kill_i: latch {req_paddr_i[PADDR_WIDTH-1:5], 5'b0} and req_way_i, clear killed and the beat counter, go to REQ.
  - req_valid_i outside IDLE is ignored; a bench assertion flags it.
- **REQ**
  - Drive l2_req_valid_o=1 and hold it, with a stable address, until l2_req_ready_i. On handshake go to BEATS.
  - The request is never retracted: a kill in REQ only sets killed.
- **BEATS**
  - Each l2_resp_valid_i writes beat cnt to line[cnt*BEAT_WIDTH +: BEAT_WIDTH], then cnt increments; cnt is log2(N_BEATS) bits and wraps.
  - On the beat with cnt==N_BEATS-1: go to DONE if killed==0, else to IDLE.
  - If l2_resp_last_i disagrees with (cnt==N_BEATS-1), pulse protocol_err_o. The counter still governs completion.
- **DONE**
  - Assert fill_valid_o for exactly one cycle, then go to IDLE.
  - If inv_valid_o is high in that cycle, hold DONE, keep fill_valid_o low, and retry next cycle. Invalidation has priority on the icache's single tag-write port.
- **Kill / invalidation**
  - req_kill_i in REQ/BEATS/DONE sets killed.
  - An l2_inv_valid_i whose line address equals the latched address during REQ/BEATS also sets killed.
  - A killed fill drains all beats and never raises fill_valid_o.
  - A kill in DONE suppresses fill_valid_o that cycle; the FSM goes to IDLE.
- **Invalidation path**: inv_valid_o/inv_paddr_o are l2_inv_* registered by one cycle, independent of FSM state.
- **Stray beats**: l2_resp_valid_i in IDLE/REQ/DONE is dropped and pulses protocol_err_o.

## Timing
- Reset (synchronous, active-high):
  - state=IDLE, killed=0, cnt=0.
  - All *_valid_o, busy_o and protocol_err_o are 0.
  - Data/address outputs are 0.
  - Reset mid-fill returns to IDLE on the next edge, no fill is emitted, and later beats count as stray.
- Cycle-level latency:
  - Request seen in IDLE at cycle t; l2_req_valid_o from t+1.
  - With l2_req_ready_i at t+1, BEATS is entered at t+2.
  - Last beat at cycle k gives fill_valid_o at k+1; busy_o falls at k+2.
  - Minimum miss-to-fill is N_BEATS+2 cycles (t+2 … t+5 beats, fill at t+6 with N_BEATS=4).
- fill_data_o, fill_paddr_o and fill_way_o are stable whenever fill_valid_o=1.
- Invalidation latency is exactly 1 cycle.

## Structure
- Add to sargantana_icache_pkg:
  - the refill_state_t enum;
  - the N_BEATS and BEAT_IDX_WIDTH localparams;
  - the structs refill_req_t, l2_req_t, l2_resp_t and ifill_resp_t.
- Sub-module sargantana_icache_line_assembler holds the beat counter plus the LINE_WIDTH data register, with write-enable, clear and last outputs. The FSM, kill/inval tracking and output registers remain in the top module.

## Test plan
- Basic fill: request with paddr 0x80001234, way 2, ready immediate, beats 0x11..,0x22..,0x33..,0x44.. back-to-back → l2_req_paddr_o=0x80001220; fill_valid_o one cycle at t+6 with the beats concatenated little-endian; fill_way_o=2.
- Backpressure and gaps: l2_req_ready_i low for 3 cycles, then beats with 2-cycle gaps → request held stable throughout; exactly one fill after beat 4; no protocol_err_o.
- Kill mid-fill: req_kill_i in BEATS after beat 1 → the remaining 3 beats are absorbed; fill_valid_o never rises; busy_o falls after the last beat.
- Invalidation collision: l2_inv_valid_i with a matching line address during BEATS → inv_valid_o one cycle later; fill dropped. A non-matching invalidation arriving in the cycle before DONE → fill delayed by exactly 1 cycle.
- Protocol errors: l2_resp_last_i on beat 2, and a stray beat in IDLE → protocol_err_o pulses twice; the fill still completes on beat 4.
- Reset mid-fill: rst_i in BEATS → all outputs 0 the next cycle; subsequent beats flag protocol_err_o; a new request then completes normally.
